// File: rtl/seven_seg_scan_drv_pkg.sv
// Shared constants for the seven-segment scan driver: segment lookup and idle pin levels.
package seven_seg_scan_drv_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [2:0] digit_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value (entry 15 first).
  localparam logic [15:0][6:0] HEX7_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seven_seg_scan_drv_hex7_dec.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_scan_drv_hex7_dec
  import seven_seg_scan_drv_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX7_LUT[nibble];

endmodule

// File: rtl/seven_seg_scan_drv.sv
// Eight-digit common-anode scan driver with frame latching, dead time, blink,
// decimal points and optional leading-zero blanking.
module seven_seg_scan_drv
  import seven_seg_scan_drv_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEAD_CYCLES  = 64,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp_num,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blink_mask,
  input  logic        lz_blank,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_sync
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned FrmW = $clog2(BLINK_FRAMES + 1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  digit_t          digit_idx_q, digit_idx_d;
  logic [FrmW-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [7:0]      shadow_dp_q, shadow_dp_d;
  logic [7:0]      shadow_blink_q, shadow_blink_d;
  logic            shadow_lz_q, shadow_lz_d;
  logic [7:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic            frame_sync_q, frame_sync_d;

  logic    slot_tick;
  logic    latch;
  digit_t  top;
  logic    lz_blanked;
  logic    en;
  nibble_t nibble;
  logic [6:0] hex_n;

  assign slot_tick = (div_cnt_q == DivW'(SCAN_DIV - 1));
  assign latch     = slot_tick && (digit_idx_q == 3'd7);
  assign nibble    = shadow_q[{digit_idx_q, 2'b00} +: 4];

  seven_seg_scan_drv_hex7_dec u_hex7_dec (
    .nibble (nibble),
    .seg_n  (hex_n)
  );

  // Ascending scan so the highest nonzero nibble wins.
  always_comb begin
    top = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (shadow_q[4*k +: 4] != 4'h0) top = 3'(k);
    end
  end

  assign lz_blanked = shadow_lz_q && (digit_idx_q > top);
  assign en = (div_cnt_q >= DivW'(DEAD_CYCLES)) && !lz_blanked &&
              !(shadow_blink_q[digit_idx_q] && blink_phase_q);

  always_comb begin
    div_cnt_d      = slot_tick ? '0 : div_cnt_q + 1'b1;
    digit_idx_d    = slot_tick ? digit_idx_q + 3'd1 : digit_idx_q;
    frame_cnt_d    = frame_cnt_q;
    blink_phase_d  = blink_phase_q;
    shadow_d       = shadow_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blink_d = shadow_blink_q;
    shadow_lz_d    = shadow_lz_q;
    frame_sync_d   = latch;

    if (latch) begin
      shadow_d       = disp_num;
      shadow_dp_d    = dp_in;
      shadow_blink_d = blink_mask;
      shadow_lz_d    = lz_blank;
      if (frame_cnt_q == FrmW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + 1'b1;
      end
    end

    an_d  = en ? ~(8'b1 << digit_idx_q) : AN_OFF;
    seg_d = en ? {~shadow_dp_q[digit_idx_q], hex_n} : SEG_OFF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q      <= '0;
      digit_idx_q    <= '0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      shadow_q       <= 32'h0;
      shadow_dp_q    <= 8'h0;
      shadow_blink_q <= 8'h0;
      shadow_lz_q    <= 1'b0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      frame_sync_q   <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      digit_idx_q    <= digit_idx_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      shadow_q       <= shadow_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blink_q <= shadow_blink_d;
      shadow_lz_q    <= shadow_lz_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      frame_sync_q   <= frame_sync_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seven_seg_scan_drv.sv
// Bench for seven_seg_scan_drv: timeline-derived reference pushed to a scoreboard each
// cycle, plus directed checks at chosen slots.
module tb_seven_seg_scan_drv;

  localparam int S   = 8;
  localparam int D   = 2;
  localparam int BF  = 2;
  localparam int FRM = 8 * S;

  logic        clk;
  logic        reset;
  logic [31:0] disp_num;
  logic [7:0]  dp_in;
  logic [7:0]  blink_mask;
  logic        lz_blank;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_sync;

  int n_checks = 0;
  int n_fail   = 0;

  seven_seg_scan_drv #(
    .SCAN_DIV     (S),
    .DEAD_CYCLES  (D),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_num   (disp_num),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .frame_sync (frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_hex(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Reference state: the model derives slot/digit/frame from the edge count since release.
  int          n_edges;
  logic [31:0] m_shadow;
  logic [7:0]  m_dp, m_blink;
  logic        m_lz;
  logic [16:0] sb[$];
  logic        fs_prev;

  always @(posedge clk) begin
    if (!reset) begin
      n_edges  <= 0;
      m_shadow <= 32'h0;
      m_dp     <= 8'h0;
      m_blink  <= 8'h0;
      m_lz     <= 1'b0;
      sb.delete();
    end else begin
      automatic int c    = n_edges;
      automatic int div  = c % S;
      automatic int dig  = (c / S) % 8;
      automatic int f    = c / FRM;
      automatic int top  = 0;
      automatic logic ph = ((f / BF) % 2) == 1;
      automatic logic lit;
      automatic logic [7:0] e_an, e_seg;
      for (int k = 0; k < 8; k++) if (m_shadow[4*k +: 4] != 4'h0) top = k;
      lit   = (div >= D) && !(m_lz && dig > top) && !(m_blink[dig] && ph);
      e_an  = lit ? ~(8'h01 << dig) : 8'hFF;
      e_seg = lit ? {~m_dp[dig], ref_hex(m_shadow[4*dig +: 4])} : 8'hFF;
      sb.push_back({e_an, e_seg, ((c + 1) % FRM) == 0});
      n_edges <= c + 1;
      if (((c + 1) % FRM) == 0) begin
        m_shadow <= disp_num;
        m_dp     <= dp_in;
        m_blink  <= blink_mask;
        m_lz     <= lz_blank;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      fs_prev <= 1'b0;
    end else begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        automatic logic [16:0] e = sb.pop_front();
        chk("an", 32'(an), 32'(e[16:9]));
        chk("seg", 32'(seg), 32'(e[8:1]));
        chk("frame_sync", 32'(frame_sync), 32'(e[0]));
      end
      chk("an_onehot", 32'((an == 8'hFF) || ($countones(~an) == 1)), 32'd1);
      chk("fs_double", 32'(frame_sync && fs_prev), 32'd0);
      fs_prev <= frame_sync;
    end
  end

  task automatic wait_n(input int target);
    if (n_edges > target) chk("late_wait", 32'(n_edges), 32'(target));
    while (n_edges < target) @(negedge clk);
  endtask

  task automatic expect_at(input int target, input string tag,
                           input logic [7:0] e_an, input logic [7:0] e_seg);
    wait_n(target);
    chk({tag, "_an"}, 32'(an), 32'(e_an));
    chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; disp_num = 32'h0; dp_in = 8'h0; blink_mask = 8'h0; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_fs", 32'(frame_sync), 32'h0);
    disp_num = 32'h12345678;
    #2 reset = 1'b1;

    expect_at(1, "dead_first", 8'hFF, 8'hFF);
    expect_at(5, "pre_latch_d0", 8'hFE, 8'hC0);
    expect_at(65, "dead_f1_0", 8'hFF, 8'hFF);
    expect_at(66, "dead_f1_1", 8'hFF, 8'hFF);
    expect_at(70, "f1_d0", 8'hFE, 8'h80);
    wait_n(92);
    disp_num = 32'hDEADBEEF;
    expect_at(109, "f1_d5_old", 8'hDF, 8'hB0);
    expect_at(125, "f1_d7", 8'h7F, 8'hF9);
    expect_at(173, "f2_d5_new", 8'hDF, 8'h88);

    wait_n(200);
    disp_num = 32'h000000A0; lz_blank = 1'b1;
    expect_at(261, "lz_d0", 8'hFE, 8'hC0);
    expect_at(269, "lz_d1", 8'hFD, 8'h88);
    expect_at(301, "lz_d5", 8'hFF, 8'hFF);
    wait_n(330);
    disp_num = 32'h0;
    expect_at(389, "lz0_d0", 8'hFE, 8'hC0);
    expect_at(397, "lz0_d1", 8'hFF, 8'hFF);

    wait_n(450);
    lz_blank = 1'b0; blink_mask = 8'h01; dp_in = 8'h01;
    expect_at(517, "blink_on_a", 8'hFE, 8'h40);
    expect_at(581, "blink_on_b", 8'hFE, 8'h40);
    expect_at(645, "blink_off_a", 8'hFF, 8'hFF);
    expect_at(709, "blink_off_b", 8'hFF, 8'hFF);
    expect_at(773, "blink_on_c", 8'hFE, 8'h40);

    expect_at(780, "pre_async", 8'hFD, 8'hC0);
    #2 reset = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hFF);
    chk("async_seg", 32'(seg), 32'hFF);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    expect_at(5, "post_rst_d0", 8'hFE, 8'hC0);
    expect_at(69, "post_rst_blink_on", 8'hFE, 8'h40);
    expect_at(133, "post_rst_blink_off", 8'hFF, 8'hFF);
    wait_n(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_drv.md
Name: seven_seg_scan_drv

Overview:
- Downstream consumer of the 32-bit display word `disp_num` produced by the GPIO/test-select display register.
- Time-multiplexes eight hex digits onto a common-anode 8-digit seven-segment module: active-low anodes, active-low segments.
- Adds frame-coherent latching, anti-ghost dead time, per-digit blink and decimal points, and optional leading-zero blanking.
- Sits between the display register and the board pins.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; must be ≥ 4.
- DEAD_CYCLES, 64: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 64: full 8-digit frames per blink half-period; must be ≥ 1.

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- disp_num, in, 32: display word; nibble k is shown on digit k, digit 0 rightmost.
- dp_in, in, 8: per-digit decimal point enable, active-high.
- blink_mask, in, 8: per-digit blink enable, active-high.
- lz_blank, in, 1: leading-zero blanking enable.
- an, out, 8: digit anodes, active-low.
- seg, out, 8: {dp,g,f,e,d,c,b,a}, active-low.
- frame_sync, out, 1: one-cycle pulse when a new frame is latched.

Behaviour:
- Reset (reset=0, async): div_cnt=0, digit_idx=0, frame_cnt=0, blink_phase=0, shadow=32'h0, shadow_dp=0, shadow_blink=0, shadow_lz=0, an=8'hFF, seg=8'hFF, frame_sync=0. Release is synchronous to the next rising edge.
- Prescaler:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - slot_tick = (div_cnt==SCAN_DIV-1).
  - On slot_tick, digit_idx increments mod 8 (7→0 wraps).
- Frame latch:
  - On slot_tick with digit_idx==7: shadow<=disp_num, shadow_dp<=dp_in, shadow_blink<=blink_mask, shadow_lz<=lz_blank; frame_sync<=1 for that single cycle.
  - Input changes mid-frame have no visible effect until the next latch.
  - First latch occurs 8*SCAN_DIV cycles after reset release; until then the display shows 0s per the rules below.
- Blink:
  - On each latch, frame_cnt increments.
  - When frame_cnt reaches BLINK_FRAMES-1 and a latch occurs, frame_cnt<=0 and blink_phase toggles.
- Leading-zero rule (combinational from the shadow registers):
  - top = index of the highest nonzero nibble of shadow; top=0 if shadow==0.
  - Digit k is lz-blanked iff shadow_lz=1 and k>top. Digit 0 is never lz-blanked.
- Digit enable: en = (div_cnt ≥ DEAD_CYCLES) & ~lz-blanked(digit_idx) & ~(shadow_blink[digit_idx] & blink_phase).
- Registered outputs, 1-cycle latency from counter state:
  - an <= en ? ~(8'b1<<digit_idx) : 8'hFF.
  - seg <= en ? {~shadow_dp[digit_idx], hex7(nibble)} : 8'hFF.
  - Exactly zero or one bit of an is low in any cycle.
- hex7, active-low {g..a}:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Reset mid-frame: immediate return to reset values; an=8'hFF asynchronously.
- Counter widths: $clog2(SCAN_DIV) for div_cnt, $clog2(BLINK_FRAMES+1) for frame_cnt; no overflow beyond the defined wrap.

Decomposition:
- Shared package: HEX7 lookup constants, SEG_OFF=8'hFF, AN_OFF=8'hFF.
- One sub-module: hex7_dec (4-bit nibble → 7-bit active-low pattern, purely combinational).
- Prescaler, scan counter, shadow registers, blink and leading-zero logic stay in seven_seg_scan_drv.

Test Plan (SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2):
- Reset held low: an=8'hFF, seg=8'hFF. Assert reset=0 mid-slot while a digit is lit: an goes to 8'hFF without waiting for a clock edge.
- disp_num=32'h12345678, others 0, wait for the first frame_sync:
  - In the following frame, digit 0 slot shows an=8'hFE, seg=8'h80.
  - Digit 7 slot shows an=8'h7F, seg=8'hF9.
  - The first 2 cycles of each slot (plus 1-cycle latency) have an=8'hFF.
- Change disp_num to 32'hDEADBEEF at the middle of digit 3's slot: the current frame still shows 12345678 on all digits; the new value appears only after the next frame_sync.
- disp_num=32'h000000A0, lz_blank=1:
  - Digits 7..2 keep an=8'hFF for the whole frame.
  - Digit 1 shows seg=8'h88; digit 0 shows seg=8'hC0.
  - With disp_num=0: only digit 0 lights, seg=8'hC0.
- blink_mask=8'h01, dp_in=8'h01, disp_num=0:
  - Digit 0 shows seg=8'h40 for 2 frames, then stays dark (an=8'hFF) for 2 frames, and repeats.
  - frame_sync pulses once per 64 cycles.
- Check every cycle: an is never anything other than 8'hFF or a single zero bit; frame_sync is never high for two consecutive cycles.
